csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap controller for the RV32 core; sits in the EXE stage beside the ALU.
- Generalises the single-interrupt CSR block with:
  - NUM_EXT_IRQ maskable external interrupt lines plus the timer line, under fixed priority;
  - mcause, mtvec (direct or vectored), mscratch;
  - a WFI state machine;
  - writable 64-bit mcycle/minstret counters.

Parameters:
- NUM_EXT_IRQ, 2, number of external interrupt lines (1..16); line i maps to mip/mie bit 16+i.
- MTVEC_RESET, 32'h0001_0000, reset value of mtvec (direct mode).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- csr_valid  in  1  an instruction in EXE is a CSR/SYSTEM instruction
- csr_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI, 000 SYSTEM
- csr_addr  in  12  CSR address
- rs1_data  in  32  register source operand
- zimm  in  5  immediate source, zero-extended
- is_mret  in  1  decoded MRET (qualified by csr_valid)
- is_wfi  in  1  decoded WFI (qualified by csr_valid)
- stall  in  1  pipeline frozen (im_stall | dm_stall); no state updates except mcycle
- retire  in  1  an instruction retires this cycle
- pc  in  32  PC of the instruction in EXE
- ext_irq  in  NUM_EXT_IRQ  level-sensitive external interrupts
- timer_irq  in  1  level-sensitive timer interrupt (WDT)
- csr_rdata  out  32  old value of the addressed CSR (combinational)
- trap_take  out  1  interrupt taken this cycle (combinational)
- trap_pc  out  32  redirect target when trap_take
- mret_take  out  1  MRET executes this cycle
- mret_pc  out  32  equals mepc
- wfi_stall  out  1  registered; holds fetch while waiting

Behaviour:
- Reset: mstatus, mie, mepc, mcause, mscratch, counters, wfi_resume = 0; mtvec = MTVEC_RESET; FSM = IDLE. All outputs are 0 except mret_pc = 0 and trap_pc = MTVEC_RESET.
- mstatus:
  - Only MIE[3] and MPIE[7] are writable.
  - MPP[12:11] always reads 2'b11; all other bits read 0.
- mie:
  - Writable bits: MTIE[7], MEIE[11], and bit 16+i for each external line.
  - All other bits read 0.
- mip (read-only): MTIP[7] = timer_irq; bit 16+i = ext_irq[i]; MEIP[11] = |(ext_irq & mie[16 +: NUM_EXT_IRQ]).
- Interrupt pending:
  - pend_i = ext_irq[i] & mie[16+i] & mie[11].
  - pend_t = timer_irq & mie[7].
- Priority (csr_irq_arbiter): lowest i first, timer last.
  - External line i: cause = 32'h8000_0000 | (16+i).
  - Timer: cause = 32'h8000_0007.
- trap_take = any_pend & mstatus.MIE & ~stall.
  - Same cycle: trap_pc = {mtvec[31:2],2'b00}; if mtvec[1:0] == 01 (vectored), add 4*cause[4:0].
  - Next edge: mepc <= (FSM == WAIT) ? wfi_resume : pc; mcause <= cause; MPIE <= MIE; MIE <= 0; FSM <= IDLE.
  - The EXE instruction is squashed: no CSR write, no mret, no minstret increment.
- CSR writes (csr_valid & ~stall & ~trap_take & csr_op ∉ {000, 100}):
  - Source = rs1_data or {27'b0, zimm}.
  - RW writes the source.
  - RS/RC set/clear bits; they perform no write when the source is 0.
  - Writable: 0x300 mstatus, 0x304 mie, 0x305 mtvec (bit 1 forced 0), 0x340 mscratch, 0x341 mepc ([1:0] forced 0), 0x342 mcause, 0xB00/0xB80 mcycle lo/hi, 0xB02/0xB82 minstret lo/hi.
  - Read-only: 0x344 mip.
  - Unknown address: reads 0, writes ignored.
- mret_take = csr_valid & is_mret & ~stall & ~trap_take. Next edge: MIE <= MPIE, MPIE <= 1.
- Counters:
  - mcycle increments every cycle, including during stall.
  - minstret increments on retire & ~stall & ~trap_take.
  - A CSR write to a counter half wins over that cycle's increment; carry into the high word is not applied that cycle.
  - Both counters wrap at 2^64 with no flag.
- WFI FSM {IDLE, WAIT}:
  - IDLE -> WAIT on csr_valid & is_wfi & ~stall & ~any_pend; capture wfi_resume <= pc+4.
  - If any_pend is already set when WFI issues, WFI is a NOP.
  - WAIT -> IDLE when any_pend, regardless of mstatus.MIE. If MIE=1 the trap is taken that cycle; otherwise fetch resumes at wfi_resume.
  - wfi_stall = (FSM == WAIT). Deasserts one edge after the exit condition.
- Reset asserted mid-WAIT or mid-trap returns everything to reset values immediately.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams;
  - bit positions (MIE, MPIE, MTIE, MEIE, EXT_BASE = 16);
  - cause codes;
  - typedef enum logic {WFI_IDLE, WFI_WAIT} wfi_state_t;
  - csr_op localparams.
- Sub-module csr_irq_arbiter: parametrised combinational priority encoder. Takes pend vectors; outputs any_pend and cause.

Test Plan:
1. CSRRW 0x305 rs1 = 0x0002_0001; mie = 0x0001_0800; MIE = 1; assert ext_irq[0] -> trap_take = 1, trap_pc = 0x0002_0040, mcause = 0x8000_0010, mepc = pc, MIE = 0, MPIE = 1.
2. ext_irq = 2'b11 and timer_irq = 1, all enabled -> mcause = 0x8000_0010. Drop ext lines, run mret, retrigger timer -> mcause = 0x8000_0007.
3. WFI at pc 0x100 with MIE = 0 -> wfi_stall = 1 next cycle. Raise enabled ext_irq[1] -> wfi_stall = 0 next cycle, no trap. Repeat with MIE = 1 -> trap taken, mepc = 0x104.
4. CSRRS mstatus with rs1 = 0 -> mstatus unchanged. CSRRCI mie zimm = 0 -> no write. Write mstatus 0xFFFF_FFFF -> reads 0x0000_1888.
5. Write minstret lo = 0xFFFF_FFFF, then retire 1 -> {hi,lo} = 0x1_0000_0000. Write mcycle lo while counting -> written value holds that cycle. With stall = 1, minstret frozen and mcycle advancing.
6. Pulse rst low while in WAIT with mepc = 0x104 -> wfi_stall = 0, mepc = 0, mtvec = 0x0001_0000 immediately (asynchronous).

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR / trap unit.
//   - CSR addresses, funct3 op encodings
//   - mstatus / mie / mip bit positions, interrupt cause codes
//   - WFI state machine encoding
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // funct3 encodings
  localparam logic [2:0] OP_SYSTEM = 3'b000;
  localparam logic [2:0] OP_RW     = 3'b001;
  localparam logic [2:0] OP_RS     = 3'b010;
  localparam logic [2:0] OP_RC     = 3'b011;
  localparam logic [2:0] OP_RWI    = 3'b101;
  localparam logic [2:0] OP_RSI    = 3'b110;
  localparam logic [2:0] OP_RCI    = 3'b111;

  // Bit positions
  localparam int BIT_MIE  = 3;
  localparam int BIT_MPIE = 7;
  localparam int BIT_MTIE = 7;
  localparam int BIT_MEIE = 11;
  localparam int EXT_BASE = 16;

  // Interrupt cause codes
  localparam logic [31:0] CAUSE_IRQ   = 32'h8000_0000;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  typedef enum logic {WFI_IDLE, WFI_WAIT} wfi_state_t;

endpackage

// File: rtl/csr_irq_arbiter.sv
// csr_irq_arbiter: fixed-priority interrupt encoder.
//   pend_ext   in  NUM_EXT_IRQ  qualified pending external lines
//   pend_timer in  1            qualified pending timer interrupt
//   any_pend   out 1            any interrupt pending
//   cause      out 32           mcause value of the winner (0 when none)
// Lowest external line wins; the timer has the lowest priority.
module csr_irq_arbiter
  import csr_pkg::*;
#(
  parameter int NUM_EXT_IRQ = 2
) (
  input  logic [NUM_EXT_IRQ-1:0] pend_ext,
  input  logic                   pend_timer,
  output logic                   any_pend,
  output logic [31:0]            cause
);

  always_comb begin
    any_pend = (|pend_ext) | pend_timer;
    cause    = '0;
    if (pend_timer) cause = CAUSE_TIMER;
    // Walk from highest to lowest so the lowest pending line is assigned last.
    for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) begin
      if (pend_ext[i]) cause = CAUSE_IRQ | 32'(EXT_BASE + i);
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap controller (EXE stage).
//   clk, rst (async, active-low)
//   csr_valid/csr_op/csr_addr/rs1_data/zimm : CSR instruction in EXE
//   is_mret/is_wfi : decoded SYSTEM instructions (qualified by csr_valid)
//   stall : pipeline frozen, only mcycle advances
//   retire : instruction retires (minstret)
//   pc : PC of the EXE instruction
//   ext_irq/timer_irq : level-sensitive interrupt lines
//   csr_rdata : old value of addressed CSR (combinational)
//   trap_take/trap_pc : interrupt redirect
//   mret_take/mret_pc : MRET redirect
//   wfi_stall : registered fetch hold while waiting for an interrupt
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          NUM_EXT_IRQ = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0001_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csr_valid,
  input  logic [2:0]             csr_op,
  input  logic [11:0]            csr_addr,
  input  logic [31:0]            rs1_data,
  input  logic [4:0]             zimm,
  input  logic                   is_mret,
  input  logic                   is_wfi,
  input  logic                   stall,
  input  logic                   retire,
  input  logic [31:0]            pc,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq,
  input  logic                   timer_irq,
  output logic [31:0]            csr_rdata,
  output logic                   trap_take,
  output logic [31:0]            trap_pc,
  output logic                   mret_take,
  output logic [31:0]            mret_pc,
  output logic                   wfi_stall
);

  localparam logic [31:0] EXT_MASK  = ((32'h1 << NUM_EXT_IRQ) - 32'h1) << EXT_BASE;
  localparam logic [31:0] MIE_WMASK = EXT_MASK | (32'h1 << BIT_MTIE) | (32'h1 << BIT_MEIE);

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_r, mtvec, mscratch, mepc, mcause, wfi_resume;
  logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
  logic [31:0] mstatus_rd, mip_rd;
  wfi_state_t  state, state_n;
  logic        wfi_enter;

  logic [NUM_EXT_IRQ-1:0] pend_ext;
  logic                   pend_timer, any_pend;
  logic [31:0]            cause;

  logic [31:0] src, wdata;
  logic        csr_we, inc_instret;

  // Interrupt qualification and arbitration
  assign pend_ext   = ext_irq & mie_r[EXT_BASE +: NUM_EXT_IRQ] & {NUM_EXT_IRQ{mie_r[BIT_MEIE]}};
  assign pend_timer = timer_irq & mie_r[BIT_MTIE];

  csr_irq_arbiter #(.NUM_EXT_IRQ(NUM_EXT_IRQ)) u_arb (
    .pend_ext  (pend_ext),
    .pend_timer(pend_timer),
    .any_pend  (any_pend),
    .cause     (cause)
  );

  assign trap_take = any_pend & mst_mie & ~stall;
  assign trap_pc   = {mtvec[31:2], 2'b00} +
                     ((mtvec[1:0] == 2'b01) ? {25'b0, cause[4:0], 2'b00} : 32'h0);
  assign mret_take = csr_valid & is_mret & ~stall & ~trap_take;
  assign mret_pc   = mepc;
  assign wfi_stall = (state == WFI_WAIT);

  // Read side
  always_comb begin
    mstatus_rd           = 32'h0000_1800;  // MPP hard-wired to machine mode
    mstatus_rd[BIT_MIE]  = mst_mie;
    mstatus_rd[BIT_MPIE] = mst_mpie;
    mip_rd                              = '0;
    mip_rd[BIT_MTIE]                    = timer_irq;
    mip_rd[BIT_MEIE]                    = |(ext_irq & mie_r[EXT_BASE +: NUM_EXT_IRQ]);
    mip_rd[EXT_BASE +: NUM_EXT_IRQ]     = ext_irq;
  end

  always_comb begin
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MIE:       csr_rdata = mie_r;
      CSR_MTVEC:     csr_rdata = mtvec;
      CSR_MSCRATCH:  csr_rdata = mscratch;
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MIP:       csr_rdata = mip_rd;
      CSR_MCYCLE:    csr_rdata = mcycle_lo;
      CSR_MCYCLEH:   csr_rdata = mcycle_hi;
      CSR_MINSTRET:  csr_rdata = minstret_lo;
      CSR_MINSTRETH: csr_rdata = minstret_hi;
      default:       csr_rdata = '0;
    endcase
  end

  // Write side: funct3[2] selects the immediate; funct3[1:0] = 00 is not a CSR access.
  // Set/clear with a zero source must not write (no side effects on read-only use).
  always_comb begin
    src   = csr_op[2] ? {27'b0, zimm} : rs1_data;
    wdata = src;
    case (csr_op[1:0])
      2'b10:   wdata = csr_rdata | src;
      2'b11:   wdata = csr_rdata & ~src;
      default: wdata = src;
    endcase
    csr_we = csr_valid & ~stall & ~trap_take & (csr_op[1:0] != 2'b00) &
             ((csr_op[1:0] == 2'b01) | (src != 32'h0));
  end

  assign inc_instret = retire & ~stall & ~trap_take;

  // WFI state machine
  always_comb begin
    state_n   = state;
    wfi_enter = 1'b0;
    case (state)
      WFI_IDLE: begin
        if (csr_valid & is_wfi & ~stall & ~any_pend) begin
          state_n   = WFI_WAIT;
          wfi_enter = 1'b1;
        end
      end
      WFI_WAIT: begin
        // Leave on any pending interrupt even with MIE clear; the trap (if enabled)
        // is taken in this same cycle using wfi_resume as the return address.
        if (any_pend & ~stall) state_n = WFI_IDLE;
      end
      default: state_n = WFI_IDLE;
    endcase
    if (trap_take) state_n = WFI_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WFI_IDLE;
    else      state <= state_n;
  end

  // Architectural CSR state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_r      <= '0;
      mtvec      <= MTVEC_RESET;
      mscratch   <= '0;
      mepc       <= '0;
      mcause     <= '0;
      wfi_resume <= '0;
    end else begin
      if (trap_take) begin
        mepc     <= (state == WFI_WAIT) ? wfi_resume : pc;
        mcause   <= cause;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else begin
        if (mret_take) begin
          mst_mie  <= mst_mpie;
          mst_mpie <= 1'b1;
        end
        if (csr_we) begin
          case (csr_addr)
            CSR_MSTATUS: begin
              mst_mie  <= wdata[BIT_MIE];
              mst_mpie <= wdata[BIT_MPIE];
            end
            CSR_MIE:      mie_r    <= wdata & MIE_WMASK;
            CSR_MTVEC:    mtvec    <= {wdata[31:2], 1'b0, wdata[0]};
            CSR_MSCRATCH: mscratch <= wdata;
            CSR_MEPC:     mepc     <= {wdata[31:2], 2'b00};
            CSR_MCAUSE:   mcause   <= wdata;
            default: ;
          endcase
        end
      end
      if (wfi_enter) wfi_resume <= pc + 32'd4;
    end
  end

  // 64-bit counters; a write to either half wins and suppresses that cycle's carry.
  logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
  assign wr_cyc_lo = csr_we & (csr_addr == CSR_MCYCLE);
  assign wr_cyc_hi = csr_we & (csr_addr == CSR_MCYCLEH);
  assign wr_ins_lo = csr_we & (csr_addr == CSR_MINSTRET);
  assign wr_ins_hi = csr_we & (csr_addr == CSR_MINSTRETH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_lo   <= '0;
      mcycle_hi   <= '0;
      minstret_lo <= '0;
      minstret_hi <= '0;
    end else begin
      mcycle_lo <= wr_cyc_lo ? wdata : mcycle_lo + 32'd1;
      if (wr_cyc_hi)       mcycle_hi <= wdata;
      else if (!wr_cyc_lo) mcycle_hi <= mcycle_hi + {31'b0, &mcycle_lo};

      minstret_lo <= wr_ins_lo ? wdata : minstret_lo + {31'b0, inc_instret};
      if (wr_ins_hi)       minstret_hi <= wdata;
      else if (!wr_ins_lo) minstret_hi <= minstret_hi + {31'b0, inc_instret & (&minstret_lo)};
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: expected values are queued as stimulus
// is driven, observations are queued as outputs are sampled, and each test
// drains and compares the two queues.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        is_mret, is_wfi, stall, retire;
  logic [31:0] pc;
  logic [1:0]  ext_irq;
  logic        timer_irq;
  logic [31:0] csr_rdata, trap_pc, mret_pc;
  logic        trap_take, mret_take, wfi_stall;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];

  always #50 clk = ~clk;

  csr_trap_unit #(.NUM_EXT_IRQ(2), .MTVEC_RESET(32'h0001_0000)) dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .zimm(zimm), .is_mret(is_mret), .is_wfi(is_wfi),
    .stall(stall), .retire(retire), .pc(pc), .ext_irq(ext_irq), .timer_irq(timer_irq),
    .csr_rdata(csr_rdata), .trap_take(trap_take), .trap_pc(trap_pc),
    .mret_take(mret_take), .mret_pc(mret_pc), .wfi_stall(wfi_stall)
  );

  task automatic expect_val(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    csr_valid = 0; csr_op = 3'b000; csr_addr = 12'h000; rs1_data = 0; zimm = 0;
    is_mret = 0; is_wfi = 0; stall = 0; retire = 0;
  endtask

  task automatic csr_wr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_valid = 1; csr_op = op; csr_addr = a; rs1_data = d; zimm = d[4:0];
    tick();
    csr_valid = 0; rs1_data = 0; zimm = 0;
  endtask

  // CSRRS with a zero source: reads without side effects.
  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    csr_valid = 1; csr_op = 3'b010; csr_addr = a; rs1_data = 0; zimm = 0;
    #1;
    d = csr_rdata;
    csr_valid = 0;
  endtask

  task automatic issue_wfi(input logic [31:0] at_pc);
    pc = at_pc; csr_valid = 1; csr_op = 3'b000; is_wfi = 1;
    tick();
    csr_valid = 0; is_wfi = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    clear_inputs();
    pc = 32'h0; ext_irq = 2'b00; timer_irq = 0;
    rst = 0;
    repeat (2) tick();
    expect_val("rst_wfi_stall", 0); observe({31'b0, wfi_stall});
    expect_val("rst_trap_take", 0); observe({31'b0, trap_take});
    expect_val("rst_mret_take", 0); observe({31'b0, mret_take});
    expect_val("rst_mret_pc", 0);   observe(mret_pc);
    expect_val("rst_trap_pc", 32'h0001_0000); observe(trap_pc);
    expect_val("rst_mstatus", 32'h0000_1800); csr_rd(12'h300, d); observe(d);
    expect_val("rst_mtvec", 32'h0001_0000);   csr_rd(12'h305, d); observe(d);
    expect_val("rst_mcause", 0);              csr_rd(12'h342, d); observe(d);
    #20 rst = 1;
    tick();
    while (exp_q.size() != 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val); end
    end
  endtask

  task automatic test_trap_vectored();
    logic [31:0] d;
    csr_wr(3'b001, 12'h305, 32'h0002_0003);
    expect_val("mtvec_bit1_forced", 32'h0002_0001); csr_rd(12'h305, d); observe(d);
    csr_wr(3'b001, 12'h304, 32'h0001_0800);
    csr_wr(3'b110, 12'h300, 32'h8);
    pc = 32'h200;
    ext_irq = 2'b01;
    #1;
    expect_val("t1_trap_take", 1);          observe({31'b0, trap_take});
    expect_val("t1_trap_pc", 32'h0002_0040); observe(trap_pc);
    tick();
    ext_irq = 2'b00;
    expect_val("t1_mcause", 32'h8000_0010); csr_rd(12'h342, d); observe(d);
    expect_val("t1_mepc", 32'h200);         csr_rd(12'h341, d); observe(d);
    expect_val("t1_mstatus", 32'h1880);     csr_rd(12'h300, d); observe(d);
    while (exp_q.size() != 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val); end
    end
  endtask

  task automatic test_priority_mret();
    logic [31:0] d;
    csr_wr(3'b001, 12'h304, 32'h0003_0880);
    ext_irq = 2'b11; timer_irq = 1; pc = 32'h300;
    expect_val("t2_mip", 32'h0003_0880); csr_rd(12'h344, d); observe(d);
    csr_wr(3'b110, 12'h300, 32'h8);
    #1;
    expect_val("t2_trap_take", 1);           observe({31'b0, trap_take});
    expect_val("t2_trap_pc", 32'h0002_0040); observe(trap_pc);
    tick();
    ext_irq = 2'b00; timer_irq = 0;
    expect_val("t2_mcause_ext0", 32'h8000_0010); csr_rd(12'h342, d); observe(d);
    csr_valid = 1; csr_op = 3'b000; is_mret = 1;
    #1;
    expect_val("t2_mret_take", 1);    observe({31'b0, mret_take});
    expect_val("t2_mret_pc", 32'h300); observe(mret_pc);
    tick();
    csr_valid = 0; is_mret = 0;
    expect_val("t2_mstatus_after_mret", 32'h1888); csr_rd(12'h300, d); observe(d);
    timer_irq = 1;
    #1;
    expect_val("t2_timer_trap_pc", 32'h0002_001C); observe(trap_pc);
    tick();
    timer_irq = 0;
    expect_val("t2_mcause_timer", 32'h8000_0007); csr_rd(12'h342, d); observe(d);
    while (exp_q.size() != 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val); end
    end
  endtask

  task automatic test_wfi();
    logic [31:0] d;
    csr_wr(3'b001, 12'h304, 32'h0002_0800);
    issue_wfi(32'h100);
    expect_val("t3_wfi_stall_set", 1); observe({31'b0, wfi_stall});
    tick();
    expect_val("t3_wfi_stall_hold", 1); observe({31'b0, wfi_stall});
    ext_irq = 2'b10;
    #1;
    expect_val("t3_no_trap_mie0", 0); observe({31'b0, trap_take});
    tick();
    expect_val("t3_wfi_exit", 0);       observe({31'b0, wfi_stall});
    expect_val("t3_mepc_kept", 32'h300); csr_rd(12'h341, d); observe(d);
    issue_wfi(32'h100);
    expect_val("t3_wfi_nop_pending", 0); observe({31'b0, wfi_stall});
    ext_irq = 2'b00;
    csr_wr(3'b110, 12'h300, 32'h8);
    issue_wfi(32'h100);
    expect_val("t3_wfi_stall_mie1", 1); observe({31'b0, wfi_stall});
    pc = 32'h500;
    ext_irq = 2'b10;
    #1;
    expect_val("t3_trap_take", 1);           observe({31'b0, trap_take});
    expect_val("t3_trap_pc", 32'h0002_0044); observe(trap_pc);
    tick();
    ext_irq = 2'b00;
    expect_val("t3_wfi_exit_trap", 0);         observe({31'b0, wfi_stall});
    expect_val("t3_mepc_resume", 32'h104);     csr_rd(12'h341, d); observe(d);
    expect_val("t3_mcause", 32'h8000_0011);    csr_rd(12'h342, d); observe(d);
    while (exp_q.size() != 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val); end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] d;
    issue_wfi(32'h100);
    expect_val("t6_in_wait", 1); observe({31'b0, wfi_stall});
    #10 rst = 0;
    #1;
    expect_val("t6_wfi_stall", 0);           observe({31'b0, wfi_stall});
    expect_val("t6_trap_pc", 32'h0001_0000); observe(trap_pc);
    expect_val("t6_mepc", 0);                csr_rd(12'h341, d); observe(d);
    expect_val("t6_mtvec", 32'h0001_0000);   csr_rd(12'h305, d); observe(d);
    #10 rst = 1;
    tick();
    expect_val("t6_stays_idle", 0); observe({31'b0, wfi_stall});
    while (exp_q.size() != 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val); end
    end
  endtask

  task automatic test_csr_fields();
    logic [31:0] d;
    csr_wr(3'b001, 12'h300, 32'h80);
    csr_wr(3'b010, 12'h300, 32'h0);
    expect_val("t4_rs_zero", 32'h1880); csr_rd(12'h300, d); observe(d);
    csr_wr(3'b001, 12'h304, 32'h0001_0800);
    csr_wr(3'b111, 12'h304, 32'h0);
    expect_val("t4_rci_zero", 32'h0001_0800); csr_rd(12'h304, d); observe(d);
    csr_wr(3'b011, 12'h304, 32'h0000_0800);
    expect_val("t4_rc_mie", 32'h0001_0000); csr_rd(12'h304, d); observe(d);
    csr_wr(3'b001, 12'h300, 32'hFFFF_FFFF);
    expect_val("t4_mstatus_ones", 32'h1888); csr_rd(12'h300, d); observe(d);
    csr_wr(3'b001, 12'h304, 32'hFFFF_FFFF);
    expect_val("t4_mie_ones", 32'h0003_0880); csr_rd(12'h304, d); observe(d);
    csr_wr(3'b001, 12'h341, 32'h0000_0123);
    expect_val("t4_mepc_align", 32'h120); csr_rd(12'h341, d); observe(d);
    csr_wr(3'b001, 12'h340, 32'hDEAD_BEEF);
    expect_val("t4_mscratch", 32'hDEAD_BEEF); csr_rd(12'h340, d); observe(d);
    csr_wr(3'b001, 12'h7C0, 32'h1234_5678);
    expect_val("t4_unknown", 0); csr_rd(12'h7C0, d); observe(d);
    csr_wr(3'b001, 12'h344, 32'hFFFF_FFFF);
    expect_val("t4_mip_ro", 0); csr_rd(12'h344, d); observe(d);
    csr_wr(3'b001, 12'h304, 32'h0);
    csr_wr(3'b001, 12'h300, 32'h0);
    while (exp_q.size() != 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val); end
    end
  endtask

  task automatic test_counters();
    logic [31:0] d;
    csr_wr(3'b001, 12'hB82, 32'h0);
    csr_wr(3'b001, 12'hB02, 32'hFFFF_FFFF);
    retire = 1;
    tick();
    retire = 0;
    expect_val("t5_minstret_lo", 0); csr_rd(12'hB02, d); observe(d);
    expect_val("t5_minstret_hi", 1); csr_rd(12'hB82, d); observe(d);
    csr_wr(3'b001, 12'hB00, 32'h1000);
    expect_val("t5_mcycle_written", 32'h1000); csr_rd(12'hB00, d); observe(d);
    stall = 1; retire = 1;
    repeat (3) tick();
    expect_val("t5_mcycle_stall", 32'h1003); csr_rd(12'hB00, d); observe(d);
    expect_val("t5_minstret_frozen", 0);     csr_rd(12'hB02, d); observe(d);
    stall = 0; retire = 1;
    tick();
    retire = 0;
    expect_val("t5_minstret_run", 1); csr_rd(12'hB02, d); observe(d);
    while (exp_q.size() != 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_trap_vectored();
    test_priority_mret();
    test_wfi();
    test_reset_in_wait();
    test_csr_fields();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
